cam_capture_engine: RTL and testbench
=====================================

# cam_capture_engine

Parametrised successor to the OV7670 capture front end. Runs entirely in the `i_clk` domain and oversamples the camera's PCLK, VS, HS and DATA through synchronisers, so the pixel path needs no second clock. It assembles 2-byte pixels in either RGB565 or Y-only (grayscale) mode, with power-of-two decimation per frame and single-shot or continuous capture. It writes pixels with frame-buffer addresses to the VGA BRAM port, and reports frame count and line-length errors.

## Interface
- `DATA_WIDTH`, default 8: camera data bus width.
- `H_WIDTH`, default 320: expected pixels per line.
- `V_WIDTH`, default 240: expected lines per frame.
- `PXL_WIDTH`, default 16: output pixel width, RGB565 layout.
- `FCNT_WIDTH`, default 8: width of the frame counter.
- `i_clk`  in  1: system clock; the sole clock of the block; frequency ≥ 4× PCLK.
- `i_n_reset`  in  1: asynchronous, active-low reset.
- `i_start_capture`  in  1: one-cycle pulse; arms a capture.
- `i_continuous`  in  1: 1 = keep capturing frames; sampled at each frame end.
- `i_mode`  in  1: 0 = RGB565, 1 = Y8 taken from YUYV; latched at frame start.
- `i_decim`  in  2: decimation exponent d (0..3); keep every 2^d-th pixel and line; latched at frame start.
- `i_PCLK`, `i_VS`, `i_HS`  in  1 each: camera pixel clock and syncs (asynchronous to `i_clk`).
- `i_DATA`  in  DATA_WIDTH: camera data bus.
- `o_pixel_data`  out  PXL_WIDTH: assembled pixel.
- `o_h_addr`  out  $clog2(H_WIDTH)+1: decimated column.
- `o_v_addr`  out  $clog2(V_WIDTH)+1: decimated row.
- `o_valid`  out  1: one-cycle write strobe.
- `o_frame_done`  out  1: one-cycle pulse at the end of each captured frame.
- `o_frame_cnt`  out  FCNT_WIDTH: number of completed frames; wraps.
- `o_line_err`  out  1: sticky flag; some line's pixel count ≠ H_WIDTH.
- `o_busy`  out  1: high in every state except IDLE.
- `o_state`  out  2: current state; IDLE=0, WAIT_VS=1, FRAME=2, DONE=3.

## Operation
**Input sampling**
- PCLK, VS, HS and DATA each pass through a 2-FF synchroniser.
- A PCLK rising edge is detected when the synchronised value goes 0 to 1. Only the synchronised DATA is sampled on that detected edge.

**State machine**
- IDLE → WAIT_VS on `i_start_capture`. Clears `o_line_err`.
- WAIT_VS → FRAME on a synchronised VS falling edge (frame start).
  - Latches `i_mode` and `i_decim`.
  - Clears the h/v counters.
  - A start request arriving mid-frame therefore skips the partial frame.
- FRAME → DONE on a synchronised VS rising edge.
- DONE lasts one cycle.
  - Pulses `o_frame_done` and increments `o_frame_cnt`.
  - Goes to WAIT_VS if `i_continuous`=1, else to IDLE.
- `i_start_capture` is ignored in every state except IDLE.

**Pixel assembly (FRAME state, HS high)**
- A byte-phase bit toggles on each PCLK edge and resets to 0 at HS rising.
- Phase 0 stores the first byte. Phase 1 completes the pixel.
- RGB565 pixel = {byte0, byte1}.
- Y8 mode: Y = byte0, and pixel = {Y[7:3], Y[7:2], Y[7:3]}.

**Counters and decimation**
- `h_cnt` increments on each completed pixel and is cleared at HS rising.
- On HS falling:
  - If `h_cnt` ≠ H_WIDTH, set `o_line_err`.
  - `v_cnt` increments.
- A pixel is written only if all of the following hold:
  - `h_cnt` < H_WIDTH and `v_cnt` < V_WIDTH; overflow pixels and lines are dropped silently.
  - `h_cnt`[d-1:0] = 0 and `v_cnt`[d-1:0] = 0.
- Written address: `o_h_addr` = `h_cnt` >> d, `o_v_addr` = `v_cnt` >> d.

## Timing
- **Reset values.** Every output resets to 0, state resets to IDLE, and the internal counters and synchronisers reset to 0.
- **Write latency.** `o_valid`, `o_pixel_data` and the addresses all update in the cycle after the detected PCLK edge of byte 1. That is at most 4 `i_clk` cycles after the physical PCLK edge.
  - `o_valid` is high for exactly one cycle.
  - The data and address outputs hold their value until the next write.
- **`o_frame_done`** is high for exactly the one DONE cycle. `o_frame_cnt` takes its new value in that same cycle. After 2^FCNT_WIDTH−1 it wraps to 0.
- **VS rising during a line.** The frame ends; a half-assembled pixel is discarded.
- **HS falling on an odd byte count.** The pending byte is discarded and is not counted.
- **Reset mid-frame.** All outputs return to 0 immediately. The block returns to IDLE and does not resume capture without a new `i_start_capture`.
- **Simultaneous events.** VS falling in the same cycle as the DONE→WAIT_VS transition is not detected; capture waits for the next frame start.

## Test plan
- **RGB565 full frame.** `i_mode`=0, d=0, a 320×240 frame with bytes {0xA5, 0x5A}, one start pulse → 76800 `o_valid` strobes with pixel 0xA55A.
  - Last write at address (319, 239).
  - One `o_frame_done` pulse, `o_frame_cnt`=1, end state IDLE.
- **Y8 with decimation.** `i_mode`=1, d=1, Y=0xFF and U/V=0x00 → 19200 writes, all with pixel 0xFFFF; maximum address (159, 119).
- **Continuous mode.** `i_continuous`=1 for 3 frames → 3 `o_frame_done` pulses, `o_frame_cnt`=3, state WAIT_VS afterwards. Deassert `i_continuous` → IDLE after the next frame.
- **Line errors.** A frame where line 5 has 318 pixels and line 6 has 322 → `o_line_err`=1.
  - Line 5 leaves no write at h=318..319; line 6 writes h ≤ 319 only.
  - A new start pulse clears the flag.
- **Mid-frame start and reset.**
  - Start pulse mid-frame → no writes until after the next VS falling edge.
  - Reset asserted mid-frame → all outputs 0 within the same cycle; no writes until the next start pulse and VS falling edge.

Source files
------------

// File: rtl/cam_capture_engine.sv
// cam_capture_engine
// Camera capture front end that runs entirely in the i_clk domain.
// PCLK, VS, HS and DATA are oversampled through 2-FF synchronisers.
// Byte pairs are assembled into RGB565 or Y8-expanded pixels, decimated by
// 2^d in both axes, and written to a frame buffer port with addresses.
// The block also keeps a wrapping frame counter and a sticky line-length
// error flag.

module cam_capture_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int H_WIDTH    = 320,
  parameter int V_WIDTH    = 240,
  parameter int PXL_WIDTH  = 16,
  parameter int FCNT_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_n_reset,
  input  logic                       i_start_capture,
  input  logic                       i_continuous,
  input  logic                       i_mode,
  input  logic [1:0]                 i_decim,
  input  logic                       i_PCLK,
  input  logic                       i_VS,
  input  logic                       i_HS,
  input  logic [DATA_WIDTH-1:0]      i_DATA,
  output logic [PXL_WIDTH-1:0]       o_pixel_data,
  output logic [$clog2(H_WIDTH):0]   o_h_addr,
  output logic [$clog2(V_WIDTH):0]   o_v_addr,
  output logic                       o_valid,
  output logic                       o_frame_done,
  output logic [FCNT_WIDTH-1:0]      o_frame_cnt,
  output logic                       o_line_err,
  output logic                       o_busy,
  output logic [1:0]                 o_state
);

  // Counter widths match the address ports so a counter value can be
  // shifted straight onto the address outputs.
  localparam int HC_W = $clog2(H_WIDTH) + 1;
  localparam int VC_W = $clog2(V_WIDTH) + 1;

  localparam logic [HC_W-1:0] H_LIM  = HC_W'(H_WIDTH);
  localparam logic [VC_W-1:0] V_LIM  = VC_W'(V_WIDTH);
  localparam logic [HC_W-1:0] HC_MAX = '1;
  localparam logic [VC_W-1:0] VC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    FRAME   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;

  // Synchroniser stages and previous-value registers for edge detection.
  logic [1:0]            pclk_sync;
  logic [1:0]            vs_sync;
  logic [1:0]            hs_sync;
  logic [DATA_WIDTH-1:0] data_meta;
  logic [DATA_WIDTH-1:0] data_sync;
  logic                  pclk_prev;
  logic                  vs_prev;
  logic                  hs_prev;

  // Frame-scoped capture state.
  logic                  mode;
  logic [1:0]            decim;
  logic                  phase;
  logic [DATA_WIDTH-1:0] byte0;
  logic [HC_W-1:0]       h_cnt;
  logic [VC_W-1:0]       v_cnt;

  // Decoded events and combinational pixel/address values.
  logic                  pclk_rise;
  logic                  vs_rise;
  logic                  vs_fall;
  logic                  hs_rise;
  logic                  hs_fall;
  logic                  hs_level;
  logic [HC_W-1:0]       h_mask;
  logic [VC_W-1:0]       v_mask;
  logic                  h_on_grid;
  logic                  v_on_grid;
  logic                  write_ok;
  logic [7:0]            y_byte;
  logic [PXL_WIDTH-1:0]  rgb_pixel;
  logic [PXL_WIDTH-1:0]  y_pixel;
  logic [PXL_WIDTH-1:0]  new_pixel;
  logic [HC_W-1:0]       h_addr_next;
  logic [VC_W-1:0]       v_addr_next;

  // Two-stage synchronisers for every camera input, sharing the same latency
  // so data stays aligned with the PCLK edge that qualifies it.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      pclk_sync <= '0;
      vs_sync   <= '0;
      hs_sync   <= '0;
      data_meta <= '0;
      data_sync <= '0;
    end else begin
      pclk_sync <= {pclk_sync[0], i_PCLK};
      vs_sync   <= {vs_sync[0], i_VS};
      hs_sync   <= {hs_sync[0], i_HS};
      data_meta <= i_DATA;
      data_sync <= data_meta;
    end
  end

  // Delayed copies of the synchronised controls used to find their edges.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      pclk_prev <= 1'b0;
      vs_prev   <= 1'b0;
      hs_prev   <= 1'b0;
    end else begin
      pclk_prev <= pclk_sync[1];
      vs_prev   <= vs_sync[1];
      hs_prev   <= hs_sync[1];
    end
  end

  // Edge decode, decimation grid test and pixel formatting.
  always_comb begin
    pclk_rise = pclk_sync[1] & ~pclk_prev;
    vs_rise   = vs_sync[1] & ~vs_prev;
    vs_fall   = ~vs_sync[1] & vs_prev;
    hs_rise   = hs_sync[1] & ~hs_prev;
    hs_fall   = ~hs_sync[1] & hs_prev;
    hs_level  = hs_sync[1];

    h_mask    = HC_W'((32'd1 << decim) - 32'd1);
    v_mask    = VC_W'((32'd1 << decim) - 32'd1);
    h_on_grid = ((h_cnt & h_mask) == '0);
    v_on_grid = ((v_cnt & v_mask) == '0);
    write_ok  = (h_cnt < H_LIM) && (v_cnt < V_LIM) && h_on_grid && v_on_grid;

    h_addr_next = h_cnt >> decim;
    v_addr_next = v_cnt >> decim;

    y_byte    = byte0[DATA_WIDTH-1 -: 8];
    rgb_pixel = PXL_WIDTH'({byte0, data_sync});
    y_pixel   = PXL_WIDTH'({y_byte[7:3], y_byte[7:2], y_byte[7:3]});
    new_pixel = mode ? y_pixel : rgb_pixel;
  end

  // Capture state machine with the pixel assembly, counters and all
  // registered outputs; one block so every output changes with the state.
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state        <= IDLE;
      mode         <= 1'b0;
      decim        <= 2'd0;
      phase        <= 1'b0;
      byte0        <= '0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      o_pixel_data <= '0;
      o_h_addr     <= '0;
      o_v_addr     <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
      o_line_err   <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start_capture) begin
            state      <= WAIT_VS;
            o_line_err <= 1'b0;
          end
        end

        WAIT_VS: begin
          if (vs_fall) begin
            state <= FRAME;
            mode  <= i_mode;
            decim <= i_decim;
            h_cnt <= '0;
            v_cnt <= '0;
            phase <= 1'b0;
          end
        end

        FRAME: begin
          if (vs_rise) begin
            state        <= DONE;
            phase        <= 1'b0;
            o_frame_done <= 1'b1;
            o_frame_cnt  <= o_frame_cnt + 1'b1;
          end else if (hs_rise) begin
            phase <= 1'b0;
            h_cnt <= '0;
          end else if (hs_fall) begin
            phase <= 1'b0;
            if (h_cnt != H_LIM) begin
              o_line_err <= 1'b1;
            end
            v_cnt <= (v_cnt == VC_MAX) ? v_cnt : v_cnt + 1'b1;
          end else if (hs_level && pclk_rise) begin
            if (!phase) begin
              byte0 <= data_sync;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              h_cnt <= (h_cnt == HC_MAX) ? h_cnt : h_cnt + 1'b1;
              if (write_ok) begin
                o_valid      <= 1'b1;
                o_pixel_data <= new_pixel;
                o_h_addr     <= h_addr_next;
                o_v_addr     <= v_addr_next;
              end
            end
          end
        end

        DONE: begin
          state <= i_continuous ? WAIT_VS : IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign o_state = state;
  assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_cam_capture_engine.sv
// tb_cam_capture_engine
// Drives a scaled-down camera (8x6 frame, 2-bit frame counter) through the
// capture modes. The camera driver pushes each expected write into a queue
// and a separate monitor pops and compares on every o_valid strobe.

module tb_cam_capture_engine;

  localparam int DW  = 8;
  localparam int HW  = 8;
  localparam int VW  = 6;
  localparam int PW  = 16;
  localparam int FW  = 2;
  localparam int HAW = $clog2(HW) + 1;
  localparam int VAW = $clog2(VW) + 1;

  logic           clk;
  logic           i_n_reset;
  logic           i_start_capture;
  logic           i_continuous;
  logic           i_mode;
  logic [1:0]     i_decim;
  logic           i_PCLK;
  logic           i_VS;
  logic           i_HS;
  logic [DW-1:0]  i_DATA;
  logic [PW-1:0]  o_pixel_data;
  logic [HAW-1:0] o_h_addr;
  logic [VAW-1:0] o_v_addr;
  logic           o_valid;
  logic           o_frame_done;
  logic [FW-1:0]  o_frame_cnt;
  logic           o_line_err;
  logic           o_busy;
  logic [1:0]     o_state;

  cam_capture_engine #(
    .DATA_WIDTH(DW), .H_WIDTH(HW), .V_WIDTH(VW), .PXL_WIDTH(PW), .FCNT_WIDTH(FW)
  ) dut (
    .i_clk(clk), .i_n_reset(i_n_reset), .i_start_capture(i_start_capture),
    .i_continuous(i_continuous), .i_mode(i_mode), .i_decim(i_decim),
    .i_PCLK(i_PCLK), .i_VS(i_VS), .i_HS(i_HS), .i_DATA(i_DATA),
    .o_pixel_data(o_pixel_data), .o_h_addr(o_h_addr), .o_v_addr(o_v_addr),
    .o_valid(o_valid), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
    .o_line_err(o_line_err), .o_busy(o_busy), .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0]  pix;
    logic [HAW-1:0] h;
    logic [VAW-1:0] v;
  } wr_t;

  wr_t            exp_q[$];
  int             tests_run    = 0;
  int             tests_failed = 0;
  int             write_count  = 0;
  int             done_pulses  = 0;
  logic [PW-1:0]  last_pix     = '0;
  logic [HAW-1:0] last_h       = '0;
  logic [VAW-1:0] last_v       = '0;
  int             line_bytes[16];
  logic           exp_mode     = 1'b0;
  int             exp_d        = 0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_valid) begin
      write_count++;
      last_pix = o_pixel_data;
      last_h   = o_h_addr;
      last_v   = o_v_addr;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_write: got pix 0x%0h at (%0d,%0d), expected no write",
                 o_pixel_data, o_h_addr, o_v_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_output("write", 32'({o_pixel_data, o_h_addr, o_v_addr}),
                     32'({e.pix, e.h, e.v}));
      end
    end
    if (o_frame_done) done_pulses++;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] pat_byte(input int pattern, input int line, input int idx);
    logic [7:0] b;
    int p;
    p = idx / 2;
    case (pattern)
      0:       b = (idx % 2 == 1) ? 8'h5A : 8'hA5;
      1:       b = (idx % 2 == 1) ? 8'h00 : 8'hFF;
      default: begin
        b = {line[3:0], p[3:0]};
        if (idx % 2 == 1) b = ~b;
      end
    endcase
    return b;
  endfunction

  function automatic logic [15:0] exp_pixel(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic m);
    if (m) return {b0[7:3], b0[7:2], b0[7:3]};
    return {b0, b1};
  endfunction

  task automatic pulse_start();
    @(negedge clk) i_start_capture = 1'b1;
    @(negedge clk) i_start_capture = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_DATA = b;
    i_PCLK = 1'b0;
    clk_wait(4);
    i_PCLK = 1'b1;
    clk_wait(4);
  endtask

  task automatic reset_mid_frame();
    @(negedge clk) i_n_reset = 1'b0;
    #1;
    check_output("reset_ctrl_outputs",
                 32'({o_valid, o_frame_done, o_line_err, o_busy, o_state, o_frame_cnt}), 32'd0);
    check_output("reset_data_outputs", 32'({o_pixel_data, o_h_addr, o_v_addr}), 32'd0);
    clk_wait(3);
    i_n_reset = 1'b1;
  endtask

  // One camera frame; capt says whether the DUT should be capturing it.
  task automatic apply_stimulus(input int nlines, input int pattern, input bit capt,
                                input int start_line, input int reset_line);
    bit live;
    int step;
    logic [7:0] b0, b1;
    live = capt;
    step = 1 << exp_d;
    @(negedge clk) i_VS = 1'b0;
    clk_wait(6);
    for (int l = 0; l < nlines; l++) begin
      if (l == start_line) pulse_start();
      if (l == reset_line) begin
        reset_mid_frame();
        live = 1'b0;
      end
      i_HS = 1'b1;
      clk_wait(4);
      for (int k = 0; k < line_bytes[l]; k++) begin
        if ((k % 2 == 0) && (k + 1 < line_bytes[l]) && live) begin
          int p;
          p  = k / 2;
          b0 = pat_byte(pattern, l, k);
          b1 = pat_byte(pattern, l, k + 1);
          if (p < HW && l < VW && (p % step) == 0 && (l % step) == 0)
            exp_q.push_back(wr_t'{exp_pixel(b0, b1, exp_mode), HAW'(p / step), VAW'(l / step)});
        end
        send_byte(pat_byte(pattern, l, k));
      end
      i_PCLK = 1'b0;
      i_HS   = 1'b0;
      clk_wait(6);
    end
    i_VS = 1'b1;
    clk_wait(16);
  endtask

  task automatic configure(input logic m, input int d);
    i_mode   = m;
    i_decim  = 2'(d);
    exp_mode = m;
    exp_d    = d;
  endtask

  initial begin
    int d0;
    i_n_reset = 1'b0; i_start_capture = 1'b0; i_continuous = 1'b0;
    i_mode = 1'b0; i_decim = 2'd0; i_PCLK = 1'b0; i_VS = 1'b1; i_HS = 1'b0; i_DATA = '0;
    for (int i = 0; i < 16; i++) line_bytes[i] = 2 * HW;
    clk_wait(4);
    check_output("reset_state", 32'({o_state, o_busy}), 32'd0);
    check_output("reset_outputs",
                 32'({o_valid, o_frame_done, o_line_err, o_frame_cnt, o_h_addr, o_v_addr}), 32'd0);
    check_output("reset_pixel", 32'(o_pixel_data), 32'd0);
    i_n_reset = 1'b1;
    clk_wait(4);

    // RGB565 full frame of A5/5A
    configure(1'b0, 0);
    write_count = 0;
    pulse_start();
    check_output("armed_state", 32'({o_state, o_busy}), 32'({2'd1, 1'b1}));
    apply_stimulus(6, 0, 1'b1, -1, -1);
    check_output("rgb_writes", 32'(write_count), 32'd48);
    check_output("rgb_last_pix", 32'(last_pix), 32'hA55A);
    check_output("rgb_last_addr", 32'({last_h, last_v}), 32'({4'd7, 4'd5}));
    check_output("rgb_done", 32'(done_pulses), 32'd1);
    check_output("rgb_cnt_state", 32'({o_frame_cnt, o_state}), 32'({2'd1, 2'd0}));

    // Y8 with decimation by 2
    configure(1'b1, 1);
    write_count = 0;
    pulse_start();
    apply_stimulus(6, 1, 1'b1, -1, -1);
    check_output("y8_writes", 32'(write_count), 32'd12);
    check_output("y8_last_pix", 32'(last_pix), 32'hFFFF);
    check_output("y8_max_addr", 32'({last_h, last_v}), 32'({4'd3, 4'd2}));

    // RGB with decimation by 4 and a position-dependent pattern
    configure(1'b0, 2);
    write_count = 0;
    pulse_start();
    apply_stimulus(6, 2, 1'b1, -1, -1);
    check_output("dec4_writes", 32'(write_count), 32'd4);
    check_output("dec4_last", 32'({last_pix, last_h, last_v}), 32'({16'h44BB, 4'd1, 4'd1}));
    check_output("dec4_cnt", 32'(o_frame_cnt), 32'd3);

    // Continuous capture: counter wraps 3 -> 0 on the first frame
    configure(1'b0, 0);
    i_continuous = 1'b1;
    d0 = done_pulses;
    pulse_start();
    apply_stimulus(6, 0, 1'b1, -1, -1);
    check_output("cont_wrap_cnt", 32'(o_frame_cnt), 32'd0);
    apply_stimulus(6, 2, 1'b1, -1, -1);
    apply_stimulus(6, 0, 1'b1, -1, -1);
    check_output("cont_done", 32'(done_pulses - d0), 32'd3);
    check_output("cont_cnt_state", 32'({o_frame_cnt, o_state}), 32'({2'd2, 2'd1}));
    i_continuous = 1'b0;
    apply_stimulus(6, 0, 1'b1, -1, -1);
    check_output("cont_stop", 32'({o_frame_cnt, o_state}), 32'({2'd3, 2'd0}));

    // Short, long and odd-length lines
    line_bytes[2] = 12; line_bytes[3] = 20; line_bytes[4] = 7;
    write_count = 0;
    pulse_start();
    apply_stimulus(6, 2, 1'b1, -1, -1);
    check_output("lerr_flag", 32'(o_line_err), 32'd1);
    check_output("lerr_writes", 32'(write_count), 32'd41);
    for (int i = 0; i < 16; i++) line_bytes[i] = 2 * HW;
    pulse_start();
    check_output("lerr_cleared", 32'(o_line_err), 32'd0);
    apply_stimulus(6, 0, 1'b1, -1, -1);
    check_output("lerr_clean_frame", 32'({o_line_err, o_frame_cnt}), 32'({1'b0, 2'd1}));

    // Start request mid-frame skips the partial frame
    write_count = 0;
    apply_stimulus(6, 0, 1'b0, 2, -1);
    check_output("midstart_nowrite", 32'({write_count[7:0], 6'd0, o_state}), 32'({8'd0, 6'd0, 2'd1}));
    apply_stimulus(6, 2, 1'b1, -1, -1);
    check_output("midstart_next", 32'(write_count), 32'd48);
    check_output("midstart_cnt", 32'({o_frame_cnt, o_state}), 32'({2'd2, 2'd0}));

    // Reset mid-frame returns to IDLE and stays there
    write_count = 0;
    pulse_start();
    apply_stimulus(6, 2, 1'b1, -1, 3);
    check_output("rst_writes", 32'(write_count), 32'd24);
    check_output("rst_state", 32'({o_frame_cnt, o_state, o_busy}), 32'd0);
    apply_stimulus(6, 0, 1'b0, -1, -1);
    check_output("rst_no_resume", 32'(write_count), 32'd24);

    clk_wait(10);
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
